bmem_line_adapter: RTL

- Sits between the I-cache/D-cache miss ports and the top-level burst-memory (bmem) interface of `cpu`.
- Converts 256-bit cacheline read/write requests into 4-beat 64-bit bmem bursts.
- Arbitrates between the two caches and allows one outstanding read per cache.
- Reassembles returned read beats by matching `bmem_raddr`.

---
 rtl/mem_types_pkg.sv | 28 ++
 rtl/read_line_assembler.sv | 76 +++++++
 rtl/bmem_line_adapter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_types_pkg.sv
// Shared types and helpers for the cacheline <-> burst-memory adapter.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package mem_types_pkg;

   localparam int BEATS  = 4;
   localparam int BEAT_W = 64;
   localparam int LINE_W = BEATS * BEAT_W;

   typedef logic [LINE_W-1:0] line_t;
   typedef logic [1:0]        beat_idx_t;

   typedef enum logic {
      IDLE    = 1'b0,
      WR_BEAT = 1'b1
   } wr_state_t;

   // Cachelines are 32 bytes; the low 5 address bits never identify a line.
   function automatic logic [31:0] line_addr(input logic [31:0] addr);
      return addr & ~32'h0000_001f;
   endfunction

   // Select beat k of a line; beat 0 is the least significant 64 bits.
   function automatic logic [BEAT_W-1:0] beat_of(input line_t l, input beat_idx_t k);
      return l[{k, 6'd0} +: BEAT_W];
   endfunction

endpackage

// File: rtl/read_line_assembler.sv
// Tracks one outstanding line read and gathers its four returning beats.
// Latency: resp pulses the cycle after the last beat is accepted.
// Backpressure: none; every beat presented with beat_en is absorbed.
module read_line_assembler
   import mem_types_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              issue,
   input  logic [31:0]       issue_addr,
   input  logic              rvalid,
   input  logic [31:0]       raddr,
   input  logic              beat_en,
   input  logic [BEAT_W-1:0] rdata,
   output logic              outstanding,
   output logic [31:0]       held_addr,
   output logic              match,
   output logic              resp,
   output line_t             line_q
);

   beat_idx_t                cnt;
   logic [LINE_W-BEAT_W-1:0] partial;
   logic                     last_beat;

   // A returning beat is ours only while our read is in flight and the line matches.
   assign match     = rvalid && outstanding && (line_addr(raddr) == held_addr);
   assign last_beat = (cnt == beat_idx_t'(BEATS - 1));

   // Outstanding flag, latched line address and beat counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding <= 1'b0;
         held_addr   <= '0;
         cnt         <= '0;
      end else if (issue) begin
         outstanding <= 1'b1;
         held_addr   <= line_addr(issue_addr);
         cnt         <= '0;
      end else if (beat_en) begin
         // The counter wraps to 0 naturally after the last beat.
         cnt <= cnt + 1'b1;
         if (last_beat) begin
            outstanding <= 1'b0;
         end
      end
   end

   // Stage beats 0..2; the last beat goes straight into the completed line.
   always_ff @(posedge clk) begin
      if (rst) begin
         partial <= '0;
      end else if (beat_en && !last_beat) begin
         case (cnt)
            2'd0:    partial[63:0]    <= rdata;
            2'd1:    partial[127:64]  <= rdata;
            2'd2:    partial[191:128] <= rdata;
            default: partial          <= partial;
         endcase
      end
   end

   // Completion pulse plus the assembled line, which holds until the next completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp   <= 1'b0;
         line_q <= '0;
      end else begin
         resp <= beat_en && last_beat;
         if (beat_en && last_beat) begin
            line_q <= {rdata, partial};
         end
      end
   end

endmodule

// File: rtl/bmem_line_adapter.sv
// Bridges I/D cache line misses onto a 64-bit, 4-beat burst memory port.
// Latency: read/write issue same cycle as grant; write resp grant+4; read resp 1 cycle after last beat.
// Backpressure: new bursts wait for bmem_rdy; write beats 1..3 stream regardless of bmem_rdy.
module bmem_line_adapter
   import mem_types_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [31:0]       i_addr,
   output line_t             i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [31:0]       d_addr,
   input  line_t             d_wdata,
   output line_t             d_rdata,
   output logic              d_resp,
   output logic [31:0]       bmem_addr,
   output logic              bmem_read,
   output logic              bmem_write,
   output logic [BEAT_W-1:0] bmem_wdata,
   input  logic              bmem_rdy,
   input  logic              bmem_rvalid,
   input  logic [31:0]       bmem_raddr,
   input  logic [BEAT_W-1:0] bmem_rdata,
   output logic              proto_err
);

   wr_state_t   state;
   wr_state_t   state_nxt;
   beat_idx_t   wr_cnt;
   logic [31:0] wr_addr;
   logic        wr_last;
   logic        wr_done_q;

   logic        i_issued;
   logic        d_issued;
   logic        rr_d;

   logic        i_out;
   logic        d_out;
   logic [31:0] i_oaddr;
   logic [31:0] d_oaddr;
   logic        i_match;
   logic        d_match;
   logic        d_take;
   logic        i_rd_resp;
   logic        d_rd_resp;

   logic        i_elig;
   logic        d_rd_elig;
   logic        d_wr_elig;
   logic        d_elig;
   logic        can_grant;
   logic        grant_i;
   logic        grant_d;
   logic        grant_d_rd;
   logic        grant_d_wr;

   // Eligibility: requested, not yet issued, and not chasing a line the other port is still reading.
   assign i_elig    = i_read && !i_issued && !(d_out && (d_oaddr == line_addr(i_addr)));
   assign d_rd_elig = d_read && !d_issued && !(i_out && (i_oaddr == line_addr(d_addr)));
   assign d_wr_elig = d_write && !d_issued && !d_out;
   assign d_elig    = d_rd_elig || d_wr_elig;

   // One grant per cycle, only between bursts and only when memory is ready.
   assign can_grant  = !rst && (state == IDLE) && bmem_rdy;
   assign grant_d    = can_grant && d_elig && (rr_d || !i_elig);
   assign grant_i    = can_grant && i_elig && !grant_d;
   assign grant_d_rd = grant_d && d_rd_elig;
   assign grant_d_wr = grant_d && !d_rd_elig;

   assign wr_last = (wr_cnt == beat_idx_t'(BEATS - 1));

   // Instruction-side read tracker.
   read_line_assembler u_i_asm (
      .clk         (clk),
      .rst         (rst),
      .issue       (grant_i),
      .issue_addr  (i_addr),
      .rvalid      (bmem_rvalid),
      .raddr       (bmem_raddr),
      .beat_en     (i_match),
      .rdata       (bmem_rdata),
      .outstanding (i_out),
      .held_addr   (i_oaddr),
      .match       (i_match),
      .resp        (i_rd_resp),
      .line_q      (i_rdata)
   );

   // Data-side read tracker; the same-line guard keeps both from matching one beat.
   assign d_take = d_match && !i_match;

   read_line_assembler u_d_asm (
      .clk         (clk),
      .rst         (rst),
      .issue       (grant_d_rd),
      .issue_addr  (d_addr),
      .rvalid      (bmem_rvalid),
      .raddr       (bmem_raddr),
      .beat_en     (d_take),
      .rdata       (bmem_rdata),
      .outstanding (d_out),
      .held_addr   (d_oaddr),
      .match       (d_match),
      .resp        (d_rd_resp),
      .line_q      (d_rdata)
   );

   assign i_resp = i_rd_resp;
   assign d_resp = d_rd_resp || wr_done_q;

   // Write FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Write FSM next state: beat 0 goes out with the grant, beats 1..3 follow back to back.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_d_wr) state_nxt = WR_BEAT;
         WR_BEAT: if (wr_last)    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Burst outputs: a write burst in flight wins, otherwise whatever the arbiter granted.
   always_comb begin
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_addr  = '0;
      bmem_wdata = '0;
      if (!rst) begin
         if (state == WR_BEAT) begin
            bmem_write = 1'b1;
            bmem_addr  = wr_addr;
            bmem_wdata = beat_of(d_wdata, wr_cnt);
         end else if (grant_i) begin
            bmem_read = 1'b1;
            bmem_addr = line_addr(i_addr);
         end else if (grant_d_rd) begin
            bmem_read = 1'b1;
            bmem_addr = line_addr(d_addr);
         end else if (grant_d_wr) begin
            bmem_write = 1'b1;
            bmem_addr  = line_addr(d_addr);
            bmem_wdata = beat_of(d_wdata, 2'd0);
         end
      end
   end

   // Write beat counter, held burst address and the delayed write completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt    <= '0;
         wr_addr   <= '0;
         wr_done_q <= 1'b0;
      end else begin
         wr_done_q <= (state == WR_BEAT) && wr_last;
         if (grant_d_wr) begin
            wr_cnt  <= 2'd1;
            wr_addr <= line_addr(d_addr);
         end else if (state == WR_BEAT) begin
            wr_cnt <= wr_cnt + 1'b1;
         end
      end
   end

   // Issue-done markers block re-issue of a held request until its resp; the pointer alternates grants.
   always_ff @(posedge clk) begin
      if (rst) begin
         i_issued <= 1'b0;
         d_issued <= 1'b0;
         rr_d     <= 1'b1;
      end else begin
         if (i_resp) begin
            i_issued <= 1'b0;
         end else if (grant_i) begin
            i_issued <= 1'b1;
         end
         if (d_resp) begin
            d_issued <= 1'b0;
         end else if (grant_d) begin
            d_issued <= 1'b1;
         end
         if (grant_i) begin
            rr_d <= 1'b1;
         end else if (grant_d) begin
            rr_d <= 1'b0;
         end
      end
   end

   // Sticky flag for read beats nobody is waiting for.
   always_ff @(posedge clk) begin
      if (rst) begin
         proto_err <= 1'b0;
      end else if (bmem_rvalid && !i_match && !d_match) begin
         proto_err <= 1'b1;
      end
   end

endmodule
